// File: rtl/eco32f_fetch_pkg.sv
// Shared definitions for the eco32f fetch stage: widths, reset PC, FSM encoding,
// and the {pc, insn, fault} entry that moves through the output and skid registers.
// No logic of its own; imported by the interface, the skid buffer and the top.
package eco32f_fetch_pkg;

    localparam int ADDR_W = 32;
    localparam int INSN_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'hE000_0000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,  // no request on the bus
        ST_REQ     = 2'd1,  // request for ibus_adr outstanding, response wanted
        ST_DISCARD = 2'd2,  // request outstanding, response will be dropped
        ST_HALT    = 2'd3   // bus fault delivered, waiting for a redirect
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INSN_W-1:0] insn;
        logic              fault;
    } fetch_ent_t;

    // Instruction addresses are word aligned; drop the byte offset.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/eco32f_fetch_if.sv
// Instruction bus between the fetch stage (master) and memory (slave).
// Ports: ibus_req/ibus_adr from master; ibus_ack/ibus_err/ibus_dat from slave.
// Backpressure: a request is held until ack or err; there is no abort.
interface eco32f_fetch_if;
    import eco32f_fetch_pkg::*;

    logic              ibus_req;
    logic [ADDR_W-1:0] ibus_adr;
    logic              ibus_ack;
    logic              ibus_err;
    logic [INSN_W-1:0] ibus_dat;

    modport master (
        output ibus_req,
        output ibus_adr,
        input  ibus_ack,
        input  ibus_err,
        input  ibus_dat
    );

    modport slave (
        input  ibus_req,
        input  ibus_adr,
        output ibus_ack,
        output ibus_err,
        output ibus_dat
    );
endinterface

// File: rtl/eco32f_fetch_skid.sv
// One-entry skid buffer for a fetched {pc, insn, fault} while decode is stalled.
// Ports: clear/load/unload controls, din in; full flag and dout out. Latency 1 cycle.
// Priority is clear > load > unload; a load into a full buffer overwrites it.
module eco32f_fetch_skid
    import eco32f_fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       load,
    input  logic       unload,
    input  fetch_ent_t din,
    output logic       full,
    output fetch_ent_t dout
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
            dout <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
            dout <= din;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/eco32f_fetch.sv
// Fetch stage: owns the PC, issues one-word ibus requests, delivers {pc, insn, fault}.
// Ports: clk/rst, ibus master, stall/flush/redirect controls, if_* output register.
// Latency: ack in cycle N -> if_* in N+1. Stall holds output plus one skid entry.
module eco32f_fetch
    import eco32f_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    eco32f_fetch_if.master    ibus,
    input  logic              if_stall,
    input  logic              if_flush,
    input  logic              do_branch,
    input  logic [ADDR_W-1:0] branch_pc,
    input  logic              do_exception,
    input  logic [ADDR_W-1:0] exception_pc,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [INSN_W-1:0] if_insn,
    output logic              if_exc_ibus_fault
);

    fetch_state_t      state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [ADDR_W-1:0] adr;

    logic              redirect;
    logic [ADDR_W-1:0] target;
    logic              bus_done;
    logic              resp_keep;
    fetch_ent_t        resp_ent;

    logic              skid_full;
    logic              skid_load;
    logic              skid_unload;
    logic              skid_clear;
    fetch_ent_t        skid_ent;
    logic              out_busy;

    assign redirect  = do_exception | do_branch;
    assign target    = word_align(do_exception ? exception_pc : branch_pc);
    assign bus_done  = ibus.ibus_ack | ibus.ibus_err;
    // A response is only kept in REQ and only if no redirect kills it this cycle.
    assign resp_keep = (state == ST_REQ) && bus_done && !redirect;

    // err wins over ack: a faulting fetch carries a zero instruction word.
    assign resp_ent.pc    = adr;
    assign resp_ent.insn  = ibus.ibus_err ? '0 : ibus.ibus_dat;
    assign resp_ent.fault = ibus.ibus_err;

    // A flush frees the output register in the same cycle.
    assign out_busy    = if_valid && !if_flush;
    assign skid_clear  = redirect | if_flush;
    assign skid_load   = resp_keep && if_stall && out_busy;
    assign skid_unload = !if_stall && skid_full;

    assign ibus.ibus_req = (state == ST_REQ) || (state == ST_DISCARD);
    assign ibus.ibus_adr = adr;

    // Wherever the FSM would pass through IDLE with nothing blocking a new fetch,
    // it goes straight to REQ, so the next request is on the bus one cycle after
    // a redirect or a discarded response rather than two.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        unique case (state)
            ST_IDLE: begin
                if (redirect) begin
                    pc_n    = target;
                    state_n = if_stall ? ST_IDLE : ST_REQ;
                end else if (!if_stall && !skid_full) begin
                    state_n = ST_REQ;
                end
            end
            ST_REQ: begin
                if (redirect) begin
                    pc_n    = target;
                    // Without a response the bus cannot abort: keep req up, drop later.
                    if (bus_done) state_n = if_stall ? ST_IDLE : ST_REQ;
                    else          state_n = ST_DISCARD;
                end else if (bus_done) begin
                    pc_n = pc + 32'd4;  // wraps FFFF_FFFC -> 0
                    if (ibus.ibus_err)                state_n = ST_HALT;
                    else if (!if_stall && !skid_load) state_n = ST_REQ;
                    else                              state_n = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                if (redirect) pc_n = target;
                if (bus_done) state_n = if_stall ? ST_IDLE : ST_REQ;
            end
            ST_HALT: begin
                if (redirect) begin
                    pc_n    = target;
                    state_n = if_stall ? ST_IDLE : ST_REQ;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            pc    <= RESET_PC;
            adr   <= RESET_PC;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            // The bus address only moves when a new request starts; in DISCARD it
            // stays on the abandoned request while pc already holds the target.
            if (state_n == ST_REQ) adr <= pc_n;
        end
    end

    // Output register: skid entry first (older), then a fresh response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_valid          <= 1'b0;
            if_pc             <= '0;
            if_insn           <= '0;
            if_exc_ibus_fault <= 1'b0;
        end else if (redirect) begin
            if_valid <= 1'b0;
        end else if (!if_stall && skid_full && !if_flush) begin
            if_valid          <= 1'b1;
            if_pc             <= skid_ent.pc;
            if_insn           <= skid_ent.insn;
            if_exc_ibus_fault <= skid_ent.fault;
        end else if (resp_keep && (!if_stall || !out_busy)) begin
            // A response arriving with a flush is newer than what was flushed
            // and pc has already moved past it, so it is kept.
            if_valid          <= 1'b1;
            if_pc             <= resp_ent.pc;
            if_insn           <= resp_ent.insn;
            if_exc_ibus_fault <= resp_ent.fault;
        end else if (!if_stall || if_flush) begin
            if_valid <= 1'b0;
        end
    end

    eco32f_fetch_skid u_skid (
        .clk    (clk),
        .rst    (rst),
        .clear  (skid_clear),
        .load   (skid_load),
        .unload (skid_unload),
        .din    (resp_ent),
        .full   (skid_full),
        .dout   (skid_ent)
    );

endmodule

// File: tb/tb_eco32f_fetch.sv
// Directed bench for eco32f_fetch: reset, streaming, stall/skid, redirects,
// bus fault and resume, PC wrap, and reset in the middle of a request.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_eco32f_fetch;
    import eco32f_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_stall = 1'b0;
    logic        if_flush = 1'b0;
    logic        do_branch = 1'b0;
    logic [31:0] branch_pc = '0;
    logic        do_exception = 1'b0;
    logic [31:0] exception_pc = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_insn;
    logic        if_exc_ibus_fault;

    int n_chk  = 0;
    int n_fail = 0;

    eco32f_fetch_if bus ();

    eco32f_fetch dut (
        .clk               (clk),
        .rst               (rst),
        .ibus              (bus.master),
        .if_stall          (if_stall),
        .if_flush          (if_flush),
        .do_branch         (do_branch),
        .branch_pc         (branch_pc),
        .do_exception      (do_exception),
        .exception_pc      (exception_pc),
        .if_valid          (if_valid),
        .if_pc             (if_pc),
        .if_insn           (if_insn),
        .if_exc_ibus_fault (if_exc_ibus_fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] p,
                           input logic [31:0] i, input logic f);
        chk({tag, ".valid"}, {31'd0, if_valid}, {31'd0, v});
        if (v) begin
            chk({tag, ".pc"},    if_pc,   p);
            chk({tag, ".insn"},  if_insn, i);
            chk({tag, ".fault"}, {31'd0, if_exc_ibus_fault}, {31'd0, f});
        end
    endtask

    task automatic chk_bus(input string tag, input logic r, input logic [31:0] a);
        chk({tag, ".req"}, {31'd0, bus.ibus_req}, {31'd0, r});
        if (r) chk({tag, ".adr"}, bus.ibus_adr, a);
    endtask

    initial begin
        bus.ibus_ack = 1'b0;
        bus.ibus_err = 1'b0;
        bus.ibus_dat = '0;

        // Reset values
        tick();
        tick();
        chk("rst.req", {31'd0, bus.ibus_req}, 32'd0);
        chk("rst.adr", bus.ibus_adr, 32'hE000_0000);
        chk("rst.valid", {31'd0, if_valid}, 32'd0);
        chk("rst.pc", if_pc, 32'd0);
        chk("rst.insn", if_insn, 32'd0);
        chk("rst.fault", {31'd0, if_exc_ibus_fault}, 32'd0);

        // Release reset: request for RESET_PC on the following cycle
        rst = 1'b0;
        tick();
        chk_bus("first", 1'b1, 32'hE000_0000);

        // Zero-wait streaming
        bus.ibus_ack = 1'b1; bus.ibus_dat = 32'h11;
        tick();
        chk_out("s0", 1'b1, 32'hE000_0000, 32'h11, 1'b0);
        chk_bus("s0", 1'b1, 32'hE000_0004);
        bus.ibus_dat = 32'h22;
        tick();
        chk_out("s1", 1'b1, 32'hE000_0004, 32'h22, 1'b0);
        chk_bus("s1", 1'b1, 32'hE000_0008);
        bus.ibus_dat = 32'h33;
        tick();
        chk_out("s2", 1'b1, 32'hE000_0008, 32'h33, 1'b0);
        chk_bus("s2", 1'b1, 32'hE000_000C);

        // Stall 3 cycles; E000_000C is acked during the stall and goes to the skid
        bus.ibus_ack = 1'b0; if_stall = 1'b1;
        tick();
        chk_out("st1", 1'b1, 32'hE000_0008, 32'h33, 1'b0);
        chk_bus("st1", 1'b1, 32'hE000_000C);
        bus.ibus_ack = 1'b1; bus.ibus_dat = 32'h44;
        tick();
        chk_out("st2", 1'b1, 32'hE000_0008, 32'h33, 1'b0);
        chk_bus("st2", 1'b0, 32'h0);
        bus.ibus_ack = 1'b0;
        tick();
        chk_out("st3", 1'b1, 32'hE000_0008, 32'h33, 1'b0);
        chk_bus("st3", 1'b0, 32'h0);
        if_stall = 1'b0;
        tick();
        chk_out("unsk", 1'b1, 32'hE000_000C, 32'h44, 1'b0);
        chk_bus("unsk", 1'b0, 32'h0);
        tick();
        chk_out("resume", 1'b0, 32'h0, 32'h0, 1'b0);
        chk_bus("resume", 1'b1, 32'hE000_0010);

        // Branch to 0x1003 while E000_0010 waits 4 cycles for its ack
        do_branch = 1'b1; branch_pc = 32'h0000_1003;
        tick();
        chk_out("br1", 1'b0, 32'h0, 32'h0, 1'b0);
        chk_bus("br1", 1'b1, 32'hE000_0010);
        do_branch = 1'b0;
        tick();
        chk_bus("br2", 1'b1, 32'hE000_0010);
        tick();
        chk_bus("br3", 1'b1, 32'hE000_0010);
        bus.ibus_ack = 1'b1; bus.ibus_dat = 32'hDEAD_BEEF;
        tick();
        chk_out("br4", 1'b0, 32'h0, 32'h0, 1'b0);
        chk_bus("br4", 1'b1, 32'h0000_1000);
        bus.ibus_dat = 32'h55;
        tick();
        chk_out("br5", 1'b1, 32'h0000_1000, 32'h55, 1'b0);
        chk_bus("br5", 1'b1, 32'h0000_1004);

        // Branch and exception together: exception target wins
        bus.ibus_ack = 1'b0;
        do_branch = 1'b1; branch_pc = 32'h100;
        do_exception = 1'b1; exception_pc = 32'h200;
        tick();
        chk_out("both1", 1'b0, 32'h0, 32'h0, 1'b0);
        do_branch = 1'b0; do_exception = 1'b0;
        bus.ibus_ack = 1'b1; bus.ibus_dat = 32'h66;
        tick();
        chk_out("both2", 1'b0, 32'h0, 32'h0, 1'b0);
        chk_bus("both2", 1'b1, 32'h200);

        // Exception with a same-cycle ack: response dropped, target fetched next
        bus.ibus_dat = 32'h99;
        do_exception = 1'b1; exception_pc = 32'hE000_0004;
        tick();
        chk_out("exack", 1'b0, 32'h0, 32'h0, 1'b0);
        chk_bus("exack", 1'b1, 32'hE000_0004);

        // Bus fault on E000_0004 (err and ack together: err wins)
        do_exception = 1'b0;
        bus.ibus_err = 1'b1; bus.ibus_dat = 32'h1234_5678;
        tick();
        chk_out("err", 1'b1, 32'hE000_0004, 32'h0, 1'b1);
        chk_bus("err", 1'b0, 32'h0);
        bus.ibus_err = 1'b0; bus.ibus_ack = 1'b0;
        tick();
        chk_bus("halt1", 1'b0, 32'h0);
        tick();
        chk_bus("halt2", 1'b0, 32'h0);
        do_exception = 1'b1; exception_pc = 32'hE000_0008;
        tick();
        chk_bus("exres", 1'b1, 32'hE000_0008);
        do_exception = 1'b0;
        bus.ibus_ack = 1'b1; bus.ibus_dat = 32'hAA;
        tick();
        chk_out("exres2", 1'b1, 32'hE000_0008, 32'hAA, 1'b0);

        // PC wrap: branch (unaligned target) with same-cycle ack, then ack FFFF_FFFC
        do_branch = 1'b1; branch_pc = 32'hFFFF_FFFF;
        tick();
        chk_bus("wrap0", 1'b1, 32'hFFFF_FFFC);
        do_branch = 1'b0; bus.ibus_dat = 32'h77;
        tick();
        chk_out("wrap1", 1'b1, 32'hFFFF_FFFC, 32'h77, 1'b0);
        chk_bus("wrap1", 1'b1, 32'h0);
        bus.ibus_ack = 1'b0;
        tick();
        chk_bus("wrap2", 1'b1, 32'h0);

        // Reset in the middle of a request: asynchronous return to reset values
        rst = 1'b1;
        #1;
        chk("mrst.req", {31'd0, bus.ibus_req}, 32'd0);
        chk("mrst.adr", bus.ibus_adr, 32'hE000_0000);
        chk("mrst.valid", {31'd0, if_valid}, 32'd0);
        chk("mrst.pc", if_pc, 32'd0);
        bus.ibus_ack = 1'b1; bus.ibus_dat = 32'hBB;
        tick();
        chk("mrst.req2", {31'd0, bus.ibus_req}, 32'd0);
        chk("mrst.valid2", {31'd0, if_valid}, 32'd0);
        bus.ibus_ack = 1'b0;
        rst = 1'b0;
        tick();
        chk_bus("rerun", 1'b1, 32'hE000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
